// File: rtl/tone_player.sv
// tone_player: beat-sequenced square-wave tone generator.
//   Walks a song table one quarter-beat at a time (beat_num out, tone in)
//   and synthesises a square wave at the current tone frequency using a
//   phase accumulator that toggles audio every CLK_FREQ/2 of accumulated Hz.
// Ports:
//   clk      - system clock, all state on rising edge
//   rst      - synchronous active-high reset
//   start    - one-cycle request to (re)start playback at beat 0
//   pause    - level, freezes playback while high
//   loop_en  - level, wrap to beat 0 after LAST_BEAT instead of finishing
//   tone     - Hz for the current beat, from the song table
//   beat_num - current quarter-beat index (registered)
//   audio    - square-wave output (registered)
//   playing  - high while playing or paused
//   done     - one-cycle pulse when the song ends without looping
module tone_player #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BEAT_HZ    = 8,
  parameter int unsigned LAST_BEAT  = 107,
  parameter int unsigned SILENCE_HZ = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        loop_en,
  input  logic [31:0] tone,
  output logic [7:0]  beat_num,
  output logic        audio,
  output logic        playing,
  output logic        done
);

  localparam int unsigned BEAT_TICKS = CLK_FREQ / BEAT_HZ;
  localparam int unsigned HALF       = CLK_FREQ / 2;
  localparam int unsigned TW         = $clog2(BEAT_TICKS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BEAT_TICKS - 1);
  localparam logic [7:0]    BEAT_LAST  = 8'(LAST_BEAT);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_acc;
  logic [31:0]   r_tone_q;
  logic [7:0]    r_beat;
  logic          r_audio;
  logic          r_playing;
  logic          r_done;

  logic          w_silent;
  logic [31:0]   w_sum;
  logic          w_cross;
  logic          w_timer_last;

  assign w_silent     = (r_tone_q == '0) || (r_tone_q >= SILENCE_HZ);
  // r_acc stays below HALF, so the sum cannot overflow 32 bits for tones <= 2**31
  assign w_sum        = r_acc + r_tone_q;
  assign w_cross      = (w_sum >= HALF);
  assign w_timer_last = (r_timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_acc     <= '0;
      r_tone_q  <= '0;
      r_beat    <= '0;
      r_audio   <= 1'b0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tone_q <= tone;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_audio <= 1'b0;
          r_beat  <= '0;
          if (start) begin
            r_state   <= S_PLAY;
            r_playing <= 1'b1;
            r_timer   <= '0;
            r_acc     <= '0;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_audio   <= 1'b0;
          r_playing <= 1'b0;
        end
        S_PLAY, S_PAUSE: begin
          if (start) begin
            r_state <= S_PLAY;
            r_beat  <= '0;
            r_timer <= '0;
            r_acc   <= '0;
            r_audio <= 1'b0;
          end else if (pause) begin
            // everything holds; only the state changes
            r_state <= S_PAUSE;
          end else begin
            // the cycle that leaves PAUSE is itself a playing cycle, so a
            // pause of N cycles delays the next beat by exactly N
            r_state <= S_PLAY;
            if (w_silent) begin
              r_acc   <= '0;
              r_audio <= 1'b0;
            end else if (w_cross) begin
              r_acc   <= w_sum - HALF;
              r_audio <= ~r_audio;
            end else begin
              r_acc <= w_sum;
            end
            if (w_timer_last) begin
              r_timer <= '0;
              if (r_beat == BEAT_LAST) begin
                r_beat <= '0;
                if (!loop_en) begin
                  r_state   <= S_DONE;
                  r_playing <= 1'b0;
                  r_done    <= 1'b1;
                  r_audio   <= 1'b0;
                  r_acc     <= '0;
                end
              end else begin
                r_beat <= r_beat + 8'd1;
              end
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign beat_num = r_beat;
  assign audio    = r_audio;
  assign playing  = r_playing;
  assign done     = r_done;

endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed table, hand-written silence sequence and random
// stimulus for tone_player, checked against a behavioural model.
module tb_tone_player;

  localparam int unsigned CLK_FREQ   = 1000;
  localparam int unsigned BEAT_HZ    = 10;
  localparam int unsigned LAST_BEAT  = 3;
  localparam int unsigned SILENCE_HZ = 20000;
  localparam longint      PERIOD     = CLK_FREQ / BEAT_HZ;
  localparam longint      HALF       = CLK_FREQ / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        loop_en = 1'b0;
  logic [31:0] tone;
  logic [7:0]  beat_num;
  logic        audio;
  logic        playing;
  logic        done;

  logic [31:0] song [4];

  always #5 clk = ~clk;

  always_comb tone = (beat_num <= 8'd3) ? song[beat_num[1:0]] : 32'd0;

  tone_player #(
    .CLK_FREQ  (CLK_FREQ),
    .BEAT_HZ   (BEAT_HZ),
    .LAST_BEAT (LAST_BEAT),
    .SILENCE_HZ(SILENCE_HZ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pause   (pause),
    .loop_en (loop_en),
    .tone    (tone),
    .beat_num(beat_num),
    .audio   (audio),
    .playing (playing),
    .done    (done)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Behavioural model: audio level is the parity of how many half-periods
  // of accumulated phase (sum of Hz per playing cycle) have elapsed since the
  // last phase reset.
  typedef enum {M_IDLE, M_PLAY, M_PAUSE, M_DONE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_beat = 0;
  longint m_in_beat = 0;
  longint m_total = 0;
  longint m_tq = 0;
  bit     m_done = 0;

  function automatic bit is_silent(longint t);
    return (t == 0) || (t >= SILENCE_HZ);
  endfunction

  function automatic void model_step(bit r, bit s, bit p, bit l);
    longint next_tq;
    next_tq = song[m_beat];
    m_done = 0;
    if (r) begin
      m_mode = M_IDLE; m_beat = 0; m_in_beat = 0; m_total = 0; m_tq = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_PLAY; m_beat = 0; m_in_beat = 0; m_total = 0; end
      M_DONE: m_mode = M_IDLE;
      default: begin
        if (s) begin
          m_mode = M_PLAY; m_beat = 0; m_in_beat = 0; m_total = 0;
        end else if (p) begin
          m_mode = M_PAUSE;
        end else begin
          m_mode = M_PLAY;
          if (is_silent(m_tq)) m_total = 0;
          else m_total += m_tq;
          m_in_beat++;
          if (m_in_beat == PERIOD) begin
            m_in_beat = 0;
            if (m_beat == LAST_BEAT) begin
              m_beat = 0;
              if (!l) begin m_mode = M_DONE; m_done = 1; m_total = 0; end
            end else begin
              m_beat++;
            end
          end
        end
      end
    endcase
    m_tq = next_tq;
  endfunction

  function automatic bit m_audio();
    return (m_mode == M_PLAY || m_mode == M_PAUSE) && (((m_total / HALF) % 2) == 1);
  endfunction

  task automatic cycle(input bit r, input bit s, input bit p, input bit l);
    rst = r; start = s; pause = p; loop_en = l;
    @(posedge clk);
    model_step(r, s, p, l);
    #1;
    chk("model beat_num", {24'd0, beat_num}, m_beat);
    chk("model audio", {31'd0, audio}, {31'd0, m_audio()});
    chk("model playing", {31'd0, playing}, (m_mode == M_PLAY || m_mode == M_PAUSE) ? 1 : 0);
    chk("model done", {31'd0, done}, {31'd0, m_done});
  endtask

  typedef struct {
    int       n;
    bit       r, s, p, l;
    bit [7:0] beat;
    bit       aud, ply, dn;
  } vec_t;

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < 4; i++) song[i] = 32'd100;

    tbl = '{
      '{2,   1,0,0,0, 8'd0, 0,0,0},  // reset
      '{1,   0,1,0,0, 8'd0, 0,1,0},  // start
      '{4,   0,0,0,0, 8'd0, 0,1,0},
      '{1,   0,0,0,0, 8'd0, 1,1,0},  // first toggle 5 cycles in
      '{5,   0,0,0,0, 8'd0, 0,1,0},
      '{89,  0,0,0,0, 8'd0, 1,1,0},
      '{1,   0,0,0,0, 8'd1, 0,1,0},  // beat 1 at cycle 100
      '{37,  0,0,1,0, 8'd1, 0,1,0},  // frozen
      '{99,  0,0,0,0, 8'd1, 1,1,0},
      '{1,   0,0,0,0, 8'd2, 0,1,0},  // boundary delayed by exactly 37
      '{100, 0,0,0,0, 8'd3, 0,1,0},
      '{99,  0,0,0,0, 8'd3, 1,1,0},
      '{1,   0,0,0,0, 8'd0, 0,0,1},  // done pulse
      '{1,   0,0,0,0, 8'd0, 0,0,0},  // idle
      '{1,   0,1,1,0, 8'd0, 0,1,0},  // start with pause -> PLAY
      '{1,   0,0,1,0, 8'd0, 0,1,0},  // -> PAUSE
      '{3,   0,0,1,0, 8'd0, 0,1,0},
      '{5,   0,0,0,0, 8'd0, 1,1,0},
      '{1,   1,0,0,0, 8'd0, 0,0,0},  // reset mid-play with audio high
      '{1,   0,1,0,1, 8'd0, 0,1,0},
      '{400, 0,0,0,1, 8'd0, 0,1,0},  // looped 3 -> 0, no done
      '{203, 0,0,0,1, 8'd2, 0,1,0},
      '{1,   0,1,0,1, 8'd0, 0,1,0},  // restart at beat 2
      '{4,   0,0,0,1, 8'd0, 0,1,0},  // accumulator was cleared
      '{1,   0,0,0,1, 8'd0, 1,1,0},
      '{1,   1,0,0,0, 8'd0, 0,0,0}
    };

    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++)
        cycle(tbl[k].r, tbl[k].s, tbl[k].p, tbl[k].l);
      chk($sformatf("tbl[%0d] beat_num", k), {24'd0, beat_num}, {24'd0, tbl[k].beat});
      chk($sformatf("tbl[%0d] audio", k),    {31'd0, audio},    {31'd0, tbl[k].aud});
      chk($sformatf("tbl[%0d] playing", k),  {31'd0, playing},  {31'd0, tbl[k].ply});
      chk($sformatf("tbl[%0d] done", k),     {31'd0, done},     {31'd0, tbl[k].dn});
    end

    // silent beats (0 and SILENCE_HZ) and restart of phase afterwards
    song[0] = 32'd100; song[1] = 32'd0; song[2] = 32'd100; song[3] = 32'd20000;
    cycle(0, 1, 0, 0);
    for (int j = 0; j < 150; j++) begin
      cycle(0, 0, 0, 0);
      if (j >= 102) chk("silent beat audio", {31'd0, audio}, 32'd0);
    end
    for (int j = 0; j < 55; j++) cycle(0, 0, 0, 0);
    chk("post-silence beat", {24'd0, beat_num}, 32'd2);
    chk("post-silence before toggle", {31'd0, audio}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("post-silence first toggle", {31'd0, audio}, 32'd1);
    for (int j = 0; j < 110; j++) begin
      cycle(0, 0, 0, 0);
      if (j >= 96 && j < 105) chk("20000Hz beat audio", {31'd0, audio}, 32'd0);
    end
    cycle(1, 0, 0, 0);

    // random phase
    begin
      bit p, l;
      p = 0; l = 0;
      for (int ep = 0; ep < 6; ep++) begin
        for (int i = 0; i < 4; i++) begin
          case ($urandom_range(0, 5))
            0: song[i] = 32'd0;
            1: song[i] = 32'd20000;
            2: song[i] = 32'd20000 + $urandom_range(0, 1000);
            3: song[i] = 32'd100;
            default: song[i] = $urandom_range(1, 499);
          endcase
        end
        for (int c = 0; c < 800; c++) begin
          if ($urandom_range(0, 39) == 0) p = ~p;
          if ($urandom_range(0, 199) == 0) l = ~l;
          cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) == 0), p, l);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
